aoc5_tuple_packer: RTL and testbench

Transmit-side front end for the AOC5 sort/merge datapath. Accepts a serial stream of `tuple_pair_t` values over a valid/ready handshake and packs consecutive tuples into even/odd row writes with an incrementing row address. Emits the row-write strobe and the end-of-stream pulse that the ping bank's initial load phase consumes. Pads an odd-length stream with a sentinel that sorts last.

---
 rtl/aoc5_tuple_packer_pkg.sv | 27 ++
 rtl/aoc5_tuple_packer.sv | 162 ++++++++++++++++
 tb/tb_aoc5_tuple_packer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aoc5_tuple_packer_pkg.sv
// Shared AOC5 header: tuple format, bank geometry, padding sentinel and
// the packer state encoding used by the sort/merge datapath.
package aoc5_tuple_packer_pkg;

  // Row address width of one ping/pong bank; capacity is 2**BANK_ADDR_WIDTH rows.
  localparam int BANK_ADDR_WIDTH = 4;

  localparam int TUPLE_KEY_WIDTH   = 32;
  localparam int TUPLE_VALUE_WIDTH = 32;

  typedef struct packed {
    logic [TUPLE_KEY_WIDTH-1:0]   key;
    logic [TUPLE_VALUE_WIDTH-1:0] value;
  } tuple_pair_t;

  // All-ones sentinel: compares greater than any real tuple, so it sorts last
  // and the merge stages can recognise it as filler.
  localparam tuple_pair_t PAD_TUPLE = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2,
    DONE = 2'd3
  } packer_state_t;

endpackage

// File: rtl/aoc5_tuple_packer.sv
// Packs a valid/ready tuple stream into {even, odd} row writes with an
// incrementing row address. Odd-length streams are padded with PAD_TUPLE.
// Rows beyond bank capacity are dropped and flagged via a sticky overflow.
module aoc5_tuple_packer
  import aoc5_tuple_packer_pkg::*;
#(
  parameter int ADDR_WIDTH = BANK_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start_in,
  input  logic                  tuple_valid_in,
  output logic                  tuple_ready_out,
  input  tuple_pair_t           tuple_data_in,
  input  logic                  tuple_last_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output tuple_pair_t           even_data_out,
  output tuple_pair_t           odd_data_out,
  output logic                  data_valid_out,
  output logic                  stream_done_out,
  output logic [31:0]           tuple_count_out,
  output logic [ADDR_WIDTH:0]   row_count_out,
  output logic                  overflow_out
);

  packer_state_t         state_q, state_d;
  tuple_pair_t           held_even_q, held_even_d;
  logic                  ready_q, ready_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  tuple_pair_t           even_data_q, even_data_d;
  tuple_pair_t           odd_data_q, odd_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  stream_done_q, stream_done_d;
  logic [31:0]           tuple_count_q, tuple_count_d;
  logic [ADDR_WIDTH:0]   row_count_q, row_count_d;
  logic                  overflow_q, overflow_d;

  logic        accept;
  logic        row_wr;
  logic        bank_full;
  tuple_pair_t row_even;
  tuple_pair_t row_odd;

  // ready is registered, so the handshake is qualified by the flopped copy
  assign accept    = tuple_valid_in && ready_q;
  // row_count never exceeds capacity, so its MSB alone marks a full bank
  assign bank_full = row_count_q[ADDR_WIDTH];

  // Next-state, pairing and row-write logic; all outputs come from flops.
  always_comb begin
    state_d       = state_q;
    held_even_d   = held_even_q;
    addr_d        = addr_q;
    even_data_d   = even_data_q;
    odd_data_d    = odd_data_q;
    data_valid_d  = 1'b0;
    stream_done_d = 1'b0;
    tuple_count_d = tuple_count_q;
    row_count_d   = row_count_q;
    overflow_d    = overflow_q;
    row_wr        = 1'b0;
    row_even      = '0;
    row_odd       = '0;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          tuple_count_d = '0;
          row_count_d   = '0;
          addr_d        = '0;
          overflow_d    = 1'b0;
          state_d       = EVEN;
        end
      end
      EVEN: begin
        if (accept) begin
          tuple_count_d = tuple_count_q + 32'd1;
          if (tuple_last_in) begin
            row_wr   = 1'b1;
            row_even = tuple_data_in;
            row_odd  = PAD_TUPLE;
            state_d  = DONE;
          end else begin
            held_even_d = tuple_data_in;
            state_d     = ODD;
          end
        end
      end
      ODD: begin
        if (accept) begin
          tuple_count_d = tuple_count_q + 32'd1;
          row_wr        = 1'b1;
          row_even      = held_even_q;
          row_odd       = tuple_data_in;
          state_d       = tuple_last_in ? DONE : EVEN;
        end
      end
      DONE: begin
        // Done pulse lands the cycle after the final row strobe, never with it.
        stream_done_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The row index and row count advance together, so the count doubles as
    // the address of the next row. A full bank drops the row silently.
    if (row_wr) begin
      if (bank_full) begin
        overflow_d = 1'b1;
      end else begin
        data_valid_d = 1'b1;
        addr_d       = row_count_q[ADDR_WIDTH-1:0];
        even_data_d  = row_even;
        odd_data_d   = row_odd;
        row_count_d  = row_count_q + (ADDR_WIDTH+1)'(1);
      end
    end

    ready_d = (state_d == EVEN) || (state_d == ODD);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      held_even_q   <= '0;
      ready_q       <= 1'b0;
      addr_q        <= '0;
      even_data_q   <= '0;
      odd_data_q    <= '0;
      data_valid_q  <= 1'b0;
      stream_done_q <= 1'b0;
      tuple_count_q <= '0;
      row_count_q   <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      held_even_q   <= held_even_d;
      ready_q       <= ready_d;
      addr_q        <= addr_d;
      even_data_q   <= even_data_d;
      odd_data_q    <= odd_data_d;
      data_valid_q  <= data_valid_d;
      stream_done_q <= stream_done_d;
      tuple_count_q <= tuple_count_d;
      row_count_q   <= row_count_d;
      overflow_q    <= overflow_d;
    end
  end

  assign tuple_ready_out = ready_q;
  assign addr_out        = addr_q;
  assign even_data_out   = even_data_q;
  assign odd_data_out    = odd_data_q;
  assign data_valid_out  = data_valid_q;
  assign stream_done_out = stream_done_q;
  assign tuple_count_out = tuple_count_q;
  assign row_count_out   = row_count_q;
  assign overflow_out    = overflow_q;

endmodule

// File: tb/tb_aoc5_tuple_packer.sv
// Directed bench for aoc5_tuple_packer with a 4-row bank (ADDR_WIDTH = 2).
// Expected rows are queued as beats are driven; a monitor logs observed rows.
module tb_aoc5_tuple_packer;
  import aoc5_tuple_packer_pkg::*;

  localparam int AW = 2;
  localparam int CAP = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start_in = 1'b0;
  logic          tuple_valid_in = 1'b0;
  logic          tuple_ready_out;
  tuple_pair_t   tuple_data_in = '0;
  logic          tuple_last_in = 1'b0;
  logic [AW-1:0] addr_out;
  tuple_pair_t   even_data_out;
  tuple_pair_t   odd_data_out;
  logic          data_valid_out;
  logic          stream_done_out;
  logic [31:0]   tuple_count_out;
  logic [AW:0]   row_count_out;
  logic          overflow_out;

  aoc5_tuple_packer #(.ADDR_WIDTH(AW)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start_in       (start_in),
    .tuple_valid_in (tuple_valid_in),
    .tuple_ready_out(tuple_ready_out),
    .tuple_data_in  (tuple_data_in),
    .tuple_last_in  (tuple_last_in),
    .addr_out       (addr_out),
    .even_data_out  (even_data_out),
    .odd_data_out   (odd_data_out),
    .data_valid_out (data_valid_out),
    .stream_done_out(stream_done_out),
    .tuple_count_out(tuple_count_out),
    .row_count_out  (row_count_out),
    .overflow_out   (overflow_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] addr;
    tuple_pair_t   ev;
    tuple_pair_t   od;
  } row_t;

  row_t exp_q[$];
  row_t obs_q[$];
  int   done_events = 0;

  int tests = 0;
  int fails = 0;

  // scoreboard model state
  int          model_rows;
  int          model_tuples;
  logic        model_ovf;
  logic        model_have;
  tuple_pair_t model_even;
  int          chk_ptr = 0;
  int          done_base;

  // Monitor: log every row strobe and done pulse away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      if (data_valid_out === 1'b1)
        obs_q.push_back('{addr: addr_out, ev: even_data_out, od: odd_data_out});
      if (stream_done_out === 1'b1)
        done_events++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_row(input tuple_pair_t e, input tuple_pair_t o);
    if (model_rows < CAP) begin
      exp_q.push_back('{addr: AW'(model_rows), ev: e, od: o});
      model_rows++;
    end else begin
      model_ovf = 1'b1;
    end
  endtask

  task automatic start_stream();
    model_rows   = 0;
    model_tuples = 0;
    model_ovf    = 1'b0;
    model_have   = 1'b0;
    done_base    = done_events;
    start_in = 1'b1;
    @(negedge clock);
    start_in = 1'b0;
    chk("ready_after_start", 64'(tuple_ready_out), 64'd1);
  endtask

  // Drive one beat and hold it until accepted; returns at the negedge after acceptance.
  task automatic beat(input tuple_pair_t d, input logic last);
    int k;
    tuple_valid_in = 1'b1;
    tuple_data_in  = d;
    tuple_last_in  = last;
    k = 0;
    while (tuple_ready_out !== 1'b1 && k < 50) begin
      @(negedge clock);
      k++;
    end
    chk("beat_ready", 64'(tuple_ready_out), 64'd1);
    @(negedge clock);
    tuple_valid_in = 1'b0;
    tuple_last_in  = 1'b0;
    tuple_data_in  = '0;
    model_tuples++;
    if (!model_have) begin
      if (last) push_row(d, PAD_TUPLE);
      else begin
        model_even = d;
        model_have = 1'b1;
      end
    end else begin
      push_row(model_even, d);
      model_have = 1'b0;
    end
  endtask

  function automatic tuple_pair_t rnd_tuple();
    tuple_pair_t t;
    t.key   = $urandom & 32'h7fff_ffff;
    t.value = $urandom;
    return t;
  endfunction

  task automatic compare_rows(input string tag);
    chk({tag, "_row_total"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = chk_ptr; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({tag, "_addr"}, 64'(obs_q[i].addr), 64'(exp_q[i].addr));
      chk({tag, "_even"}, obs_q[i].ev, exp_q[i].ev);
      chk({tag, "_odd"},  obs_q[i].od, exp_q[i].od);
    end
    chk_ptr = exp_q.size();
  endtask

  // Called at the negedge following the last accept edge.
  task automatic finish_stream(input string tag, input bit strobe_last);
    int k;
    if (strobe_last) begin
      chk({tag, "_final_strobe"}, 64'(data_valid_out), 64'd1);
      chk({tag, "_no_early_done"}, 64'(stream_done_out), 64'd0);
      @(negedge clock);
      chk({tag, "_done_next"}, 64'(stream_done_out), 64'd1);
      chk({tag, "_no_strobe_at_done"}, 64'(data_valid_out), 64'd0);
    end else begin
      k = 0;
      while (stream_done_out !== 1'b1 && k < 40) begin
        @(negedge clock);
        k++;
      end
      chk({tag, "_done_seen"}, 64'(stream_done_out), 64'd1);
    end
    chk({tag, "_ready_at_done"}, 64'(tuple_ready_out), 64'd0);
    chk({tag, "_tuple_count"}, 64'(tuple_count_out), 64'(model_tuples));
    chk({tag, "_row_count"}, 64'(row_count_out), 64'(model_rows));
    chk({tag, "_overflow"}, 64'(overflow_out), 64'(model_ovf));
    repeat (3) @(negedge clock);
    #1;
    chk({tag, "_done_pulses"}, 64'(done_events - done_base), 64'd1);
    chk({tag, "_counts_stable"}, 64'(tuple_count_out), 64'(model_tuples));
    compare_rows(tag);
  endtask

  initial begin
    tuple_pair_t a, b, c, d;

    // reset state
    #1;
    chk("rst_valid", 64'(data_valid_out), 64'd0);
    chk("rst_ready", 64'(tuple_ready_out), 64'd0);
    chk("rst_done", 64'(stream_done_out), 64'd0);
    chk("rst_counts", {32'(row_count_out), tuple_count_out}, 64'd0);
    chk("rst_data", even_data_out ^ odd_data_out, 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // four tuples back to back
    a = rnd_tuple(); b = rnd_tuple(); c = rnd_tuple(); d = rnd_tuple();
    start_stream();
    beat(a, 1'b0);
    beat(b, 1'b0);
    chk("b2b_row0_strobe", 64'(data_valid_out), 64'd1);
    beat(c, 1'b0);
    chk("b2b_gap_no_strobe", 64'(data_valid_out), 64'd0);
    beat(d, 1'b1);
    finish_stream("four", 1'b1);

    // three tuples, padded
    start_stream();
    beat(rnd_tuple(), 1'b0);
    beat(rnd_tuple(), 1'b0);
    beat(rnd_tuple(), 1'b1);
    finish_stream("three", 1'b1);

    // single tuple
    start_stream();
    beat(rnd_tuple(), 1'b1);
    finish_stream("single", 1'b1);

    // four tuples with valid gapped for 3 cycles between beats
    start_stream();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat (3) @(negedge clock);
      beat(rnd_tuple(), i == 3);
    end
    finish_stream("gapped", 1'b1);

    // ten tuples into a 4-row bank
    start_stream();
    for (int i = 0; i < 10; i++) beat(rnd_tuple(), i == 9);
    finish_stream("overflow", 1'b0);

    // start pulsed while in ODD is ignored; also clears overflow from before
    start_stream();
    chk("start_clears_ovf", 64'(overflow_out), 64'd0);
    beat(rnd_tuple(), 1'b0);
    start_in = 1'b1;
    beat(rnd_tuple(), 1'b0);
    start_in = 1'b0;
    beat(rnd_tuple(), 1'b0);
    beat(rnd_tuple(), 1'b1);
    finish_stream("start_in_odd", 1'b1);

    // reset mid-stream after the second of five tuples
    start_stream();
    beat(rnd_tuple(), 1'b0);
    beat(rnd_tuple(), 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(data_valid_out), 64'd0);
    chk("midrst_ready", 64'(tuple_ready_out), 64'd0);
    chk("midrst_counts", {32'(row_count_out), tuple_count_out}, 64'd0);
    chk("midrst_addr_ovf", {63'(addr_out), overflow_out}, 64'd0);
    chk("midrst_data", even_data_out ^ odd_data_out, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    #1;
    chk("midrst_no_done", 64'(done_events - done_base), 64'd0);
    compare_rows("midrst");
    start_stream();
    beat(rnd_tuple(), 1'b0);
    beat(rnd_tuple(), 1'b1);
    finish_stream("after_rst", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
